// File: rtl/demux18_seq.sv
// Registered 1-to-8 demultiplexer with a built-in sequencer.
// It steers a bit to an addressed output, or rebuilds an 8-bit serial frame into parallel outputs.
module demux18_seq #(
  parameter bit AUTO_CLEAR = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       d,
  input  logic [2:0] s,
  input  logic       load,
  input  logic       mode,
  input  logic       clr,
  output logic       y0,
  output logic       y1,
  output logic       y2,
  output logic       y3,
  output logic       y4,
  output logic       y5,
  output logic       y6,
  output logic       y7,
  output logic [2:0] ptr,
  output logic       frame_done
);

  typedef enum logic {
    ADDR = 1'b0,
    SEQ  = 1'b1
  } state_e;

  state_e     mode_q;
  logic [7:0] y_q;
  logic [7:0] shadow_q;
  logic [2:0] ptr_q;
  logic       done_q;

  // Shadow collects a frame bit by bit; y_q is only written as a whole when bit 7 arrives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q   <= ADDR;
      y_q      <= 8'h00;
      shadow_q <= 8'h00;
      ptr_q    <= 3'd0;
      done_q   <= 1'b0;
    end else begin
      mode_q <= state_e'(mode);
      done_q <= 1'b0;
      if (clr) begin
        y_q      <= 8'h00;
        shadow_q <= 8'h00;
        ptr_q    <= 3'd0;
      end else if (mode != logic'(mode_q)) begin
        shadow_q <= 8'h00;
        ptr_q    <= 3'd0;
      end else if (load) begin
        case (mode_q)
          ADDR: begin
            if (AUTO_CLEAR) y_q <= 8'h00;
            y_q[s] <= d;
            ptr_q  <= 3'd0;
          end
          SEQ: begin
            shadow_q[ptr_q] <= d;
            ptr_q           <= ptr_q + 3'd1;
            if (ptr_q == 3'd7) begin
              y_q    <= {d, shadow_q[6:0]};
              done_q <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign {y7, y6, y5, y4, y3, y2, y1, y0} = y_q;
  assign ptr        = ptr_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_demux18_seq.sv
// Directed testbench for demux18_seq: one instance with AUTO_CLEAR=0 and one with AUTO_CLEAR=1,
// both driven from the same stimulus and checked with immediate assertions.
module tb_demux18_seq;

  logic       clk;
  logic       rst;
  logic       d;
  logic [2:0] s;
  logic       load;
  logic       mode;
  logic       clr;

  logic       a0, a1, a2, a3, a4, a5, a6, a7;
  logic [2:0] aPtr;
  logic       aDone;
  logic       b0, b1, b2, b3, b4, b5, b6, b7;
  logic [2:0] bPtr;
  logic       bDone;

  logic [7:0] aY;
  logic [7:0] bY;

  int checks = 0;
  int errors = 0;

  assign aY = {a7, a6, a5, a4, a3, a2, a1, a0};
  assign bY = {b7, b6, b5, b4, b3, b2, b1, b0};

  demux18_seq #(.AUTO_CLEAR(1'b0)) dut (
    .clk(clk), .rst(rst), .d(d), .s(s), .load(load), .mode(mode), .clr(clr),
    .y0(a0), .y1(a1), .y2(a2), .y3(a3), .y4(a4), .y5(a5), .y6(a6), .y7(a7),
    .ptr(aPtr), .frame_done(aDone)
  );

  demux18_seq #(.AUTO_CLEAR(1'b1)) dutAc (
    .clk(clk), .rst(rst), .d(d), .s(s), .load(load), .mode(mode), .clr(clr),
    .y0(b0), .y1(b1), .y2(b2), .y3(b3), .y4(b4), .y5(b5), .y6(b6), .y7(b7),
    .ptr(bPtr), .frame_done(bDone)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs, then settle just after the rising edge before any check.
  task automatic applyStimulus(input logic ld, input logic md, input logic dv,
                               input logic [2:0] sv, input logic cl);
    load = ld;
    mode = md;
    d    = dv;
    s    = sv;
    clr  = cl;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkSeq(input string tag, input logic [7:0] expY,
                          input logic [2:0] expPtr, input logic expDone);
    checkOutput({tag, " y"}, aY, expY);
    checkOutput({tag, " ptr"}, {5'd0, aPtr}, {5'd0, expPtr});
    checkOutput({tag, " frame_done"}, {7'd0, aDone}, {7'd0, expDone});
  endtask

  logic [7:0] frame1;
  logic [7:0] frame2;

  initial begin
    frame1 = 8'b0100_1101;
    frame2 = 8'b0111_0110;
    rst  = 1'b1;
    load = 1'b1;
    mode = 1'b1;
    d    = 1'b0;
    s    = 3'd0;
    clr  = 1'b0;

    // Reset held with activity on the inputs.
    for (int i = 0; i < 4; i++) begin
      d = ~d;
      @(posedge clk);
      #1;
    end
    checkSeq("reset", 8'h00, 3'd0, 1'b0);
    checkOutput("reset ac y", bY, 8'h00);
    @(negedge clk);
    rst = 1'b0;

    // Addressed mode.
    applyStimulus(1'b1, 1'b0, 1'b1, 3'd3, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 3'd6, 1'b0);
    checkSeq("addr two loads", 8'b0100_1000, 3'd0, 1'b0);
    checkOutput("addr ac two loads", bY, 8'b0100_0000);
    applyStimulus(1'b1, 1'b0, 1'b0, 3'd3, 1'b0);
    checkOutput("addr overwrite y3", aY, 8'b0100_0000);
    applyStimulus(1'b0, 1'b0, 1'b1, 3'd1, 1'b0);
    checkOutput("addr hold", aY, 8'b0100_0000);
    applyStimulus(1'b1, 1'b0, 1'b1, 3'd2, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 3'd5, 1'b0);
    checkOutput("addr ac clears y2", bY, 8'b0010_0000);
    checkOutput("addr no clear", aY, 8'b0110_0100);

    // Asynchronous reset pulse between edges.
    rst = 1'b1;
    #1;
    checkOutput("async rst y", aY, 8'h00);
    checkOutput("async rst ac y", bY, 8'h00);
    #1;
    rst = 1'b0;

    // Switch to sequential; load in the switch cycle is ignored.
    applyStimulus(1'b1, 1'b1, 1'b1, 3'd0, 1'b0);
    checkSeq("seq switch", 8'h00, 3'd0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 1'b1, frame1[i], 3'd7, 1'b0);
      if (i < 7) checkSeq($sformatf("frame1 bit%0d", i), 8'h00, 3'(i + 1), 1'b0);
    end
    checkSeq("frame1 done", frame1, 3'd0, 1'b1);
    checkOutput("frame1 ac y", bY, frame1);
    applyStimulus(1'b0, 1'b1, 1'b1, 3'd0, 1'b0);
    checkSeq("frame1 pulse ends", frame1, 3'd0, 1'b0);

    // Frame with a 3-cycle stall after bit 4.
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1, frame2[i], 3'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 3'd0, 1'b0);
      checkSeq($sformatf("stall %0d", i), frame1, 3'd5, 1'b0);
    end
    for (int i = 5; i < 8; i++) applyStimulus(1'b1, 1'b1, frame2[i], 3'd0, 1'b0);
    checkSeq("frame2 done", frame2, 3'd0, 1'b1);

    // Back-to-back all-ones frame.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b1, 3'd0, 1'b0);
      if (i < 7) checkOutput($sformatf("ones bit%0d done", i), {7'd0, aDone}, 8'd0);
    end
    checkSeq("ones done", 8'hFF, 3'd0, 1'b1);

    // clr after 4 bits.
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, 1'b0, 3'd0, 1'b0);
    checkOutput("pre clr ptr", {5'd0, aPtr}, 8'd4);
    applyStimulus(1'b1, 1'b1, 1'b1, 3'd0, 1'b1);
    checkSeq("clr", 8'h00, 3'd0, 1'b0);

    // Mode switch mid-frame discards the partial frame.
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, 1'b1, 3'd0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 3'd4, 1'b0);
    checkSeq("switch to addr", 8'h00, 3'd0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 3'd4, 1'b0);
    checkSeq("first addr load", 8'b0001_0000, 3'd0, 1'b0);
    checkOutput("first addr load ac", bY, 8'b0001_0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/demux18_seq.md
Name: demux18_seq

Overview:
- Registered 1-to-8 demultiplexer with a built-in sequencer. It is the receive-side counterpart of the 8:1 select-line mux.
- Addressed mode: a single data bit is steered to the output named by a 3-bit select and held there.
- Sequential mode: an internal pointer walks outputs 0..7, so a bit stream serialised by a mux driven from a 3-bit counter is rebuilt into 8 parallel bits.
- A frame-done pulse fires on each completed frame, and the outputs update atomically at that point.

Parameters:
- AUTO_CLEAR, 0: in addressed mode, 1 = every non-selected output is cleared on a load; 0 = non-selected outputs hold their value.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- d  input  1  data bit to distribute.
- s  input  3  output select, used in addressed mode only (s=0 selects y0, ... s=7 selects y7).
- load  input  1  qualifies d; one bit is consumed per cycle while load=1.
- mode  input  1  0 = addressed, 1 = sequential.
- clr  input  1  synchronous clear of outputs, pointer and shadow register.
- y0..y7  output  1 each  registered demux outputs.
- ptr  output  3  current sequential pointer, i.e. the index of the next bit to be captured.
- frame_done  output  1  one-cycle pulse when sequential frame bit 7 is captured.

Behaviour:
- Reset: clock is clk; reset is rst, asynchronous and active-high. While rst=1, the following are forced to 0 immediately, independent of clk:
  - y0..y7, ptr, frame_done;
  - the internal 8-bit shadow register;
  - the registered mode (mode_q), so the block leaves reset in the ADDR state.
- Reset mid-frame discards any partial frame. Operation resumes on the first clk edge after rst deasserts.
- State machine: two states, ADDR and SEQ, held in mode_q. On each clk edge, mode_q <= mode.
- Mode switch cycle (mode != mode_q):
  - load is ignored and no output changes;
  - ptr <= 0, shadow <= 0, frame_done <= 0;
  - the new mode takes effect the following cycle.
- Priority per edge: rst > clr > mode switch > load.
- clr=1: y0..y7 <= 0, ptr <= 0, shadow <= 0, frame_done <= 0. load is ignored that cycle.
- ADDR state, load=1:
  - y[s] <= d. The outputs are visible 1 cycle after the edge that sampled d.
  - Other outputs hold when AUTO_CLEAR=0 and are cleared to 0 when AUTO_CLEAR=1.
  - ptr stays 0 and frame_done stays 0.
- ADDR state, load=0: all outputs hold.
- SEQ state, load=1:
  - shadow[ptr] <= d; ptr <= ptr+1, wrapping 7 -> 0 modulo 8.
  - When ptr=7: on the same edge, y0..y7 <= {d, shadow[6:0]} (bit k to yk), and frame_done <= 1 for exactly one cycle.
  - After the frame transfer, shadow is not cleared; it is overwritten bit by bit by the next frame.
- SEQ state, load=0: ptr, shadow and y hold; frame_done <= 0.
- In SEQ state, y0..y7 change only at frame completion, never mid-frame. The s input is ignored.
- Back-to-back frames (load held high continuously): frame_done pulses every 8th cycle with no gap cycles.
- load gaps in SEQ stall the pointer without losing captured bits.
- Latency:
  - ADDR: 1 cycle from load to y.
  - SEQ: y and frame_done update on the edge capturing bit 7, so they are visible 1 cycle after bit 7 is presented.
- There is no combinational path from inputs to outputs; all outputs are registered.

Test Plan:
- Reset: hold rst=1 with load=1, mode=1 and d toggling -> all y=0, ptr=0, frame_done=0. Pulse rst asynchronously between edges -> outputs clear immediately, without waiting for clk.
- ADDR, AUTO_CLEAR=0: load d=1 at s=3, then d=1 at s=6, then d=0 at s=3.
  - After the second load: y3=1, y6=1, all others 0.
  - After the third load: y3=0, y6=1.
- ADDR, AUTO_CLEAR=1: load d=1 at s=2, then d=1 at s=5 -> y5=1 only; y2 is cleared.
- SEQ, one frame: mode=1, wait one switch cycle, then present 8 bits with load=1, d sequence 1,0,1,1,0,0,1,0 (bits 0..7).
  - y0..y7 stay 0 for the first 7 cycles.
  - Then y0..y7 = 1,0,1,1,0,0,1,0, frame_done is high for one cycle, and ptr returns to 0.
- SEQ with stalls, then a second frame:
  - Insert load=0 for 3 cycles after bit 4 -> ptr holds at 5, y is unchanged, and the frame completes correctly after the gap.
  - Immediately start frame 2 as all ones -> y becomes all 1 after 8 more loads, with frame_done pulsing once.
- Disruptions mid-frame:
  - Assert clr after 4 bits -> ptr=0, y all 0, no frame_done.
  - Alternatively, switch mode to 0 mid-frame -> the partial frame is discarded, load is ignored in the switch cycle, and the first ADDR load lands the following cycle.
